// File: rtl/ccff_loader.sv
// Configuration-chain loader: accepts bitstream bytes over valid/ready and shifts
// them MSB-first onto ccff_head with a generated prog_clk, holding the fabric in reset.
module ccff_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int DIV       = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             prog_clk,
  output logic             ccff_head,
  output logic             fpga_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LEN     = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [7:0]       shift_q;
  logic [7:0]       shift_n;
  logic [2:0]       idx_q;
  logic [2:0]       idx_n;
  logic [PH_W-1:0]  ph_q;
  logic [PH_W-1:0]  ph_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             head_n;
  logic             active;

  assign active  = (state == LOAD) || (state == LOW) || (state == HIGH);
  assign cnt_inc = bit_count + 1'b1;

  // Abort outranks everything while busy; start is only honoured from IDLE/DONE.
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    idx_n   = idx_q;
    ph_n    = ph_q;
    cnt_n   = bit_count;
    head_n  = ccff_head;
    if (active && abort) begin
      state_n = IDLE;
      head_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = LOAD;
            cnt_n   = '0;
          end
        end
        LOAD: begin
          if (byte_valid && byte_ready) begin
            shift_n = byte_data;
            idx_n   = 3'd7;
            head_n  = byte_data[7];
            ph_n    = '0;
            state_n = LOW;
          end
        end
        LOW: begin
          if (ph_q == PH_LAST) begin
            ph_n    = '0;
            state_n = HIGH;
          end else begin
            ph_n = ph_q + 1'b1;
          end
        end
        HIGH: begin
          if (ph_q == PH_LAST) begin
            ph_n  = '0;
            cnt_n = cnt_inc;
            if (cnt_inc == LEN) begin
              state_n = DONE;
            end else if (idx_q == 3'd0) begin
              state_n = LOAD;
            end else begin
              idx_n   = idx_q - 3'd1;
              head_n  = shift_q[idx_n];
              state_n = LOW;
            end
          end else begin
            ph_n = ph_q + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each one tracks its state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      ph_q       <= '0;
      bit_count  <= '0;
      ccff_head  <= 1'b0;
      byte_ready <= 1'b0;
      prog_clk   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fpga_reset <= 1'b1;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      idx_q      <= idx_n;
      ph_q       <= ph_n;
      bit_count  <= cnt_n;
      ccff_head  <= head_n;
      byte_ready <= (state_n == LOAD);
      prog_clk   <= (state_n == HIGH);
      busy       <= (state_n == LOAD) || (state_n == LOW) || (state_n == HIGH);
      done       <= (state_n == DONE);
      fpga_reset <= (state_n != DONE);
    end
  end

endmodule
